// File: rtl/arithmetic_circuit.sv
// Registered arithmetic unit: {Cout,F} = A + Y + Cin over a ripple-carry chain, Y picked by {s1,s0}.
// Optional registered Z/N/V status flags when ARITH_STATUS_FLAGS_EN is defined.
module arithmetic_circuit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             s1,
    input  logic             s0,
    input  logic             Cin,
    output logic [WIDTH-1:0] F,
    output logic             Cout,
    output logic             valid
`ifdef ARITH_STATUS_FLAGS_EN
    ,
    output logic             Z,
    output logic             N,
    output logic             V
`endif
);

    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] sum;
    logic [WIDTH:0]   carry;

    logic [WIDTH-1:0] f_q, f_d;
    logic             cout_q, cout_d;
    logic             valid_q, valid_d;

    always_comb begin
        y = B;
        case ({s1, s0})
            2'b00:   y = B;
            2'b01:   y = ~B;
            2'b10:   y = '0;
            default: y = '1;
        endcase
    end

    assign carry[0] = Cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum[i]     = A[i] ^ y[i] ^ carry[i];
        assign carry[i+1] = (A[i] & y[i]) | (carry[i] & (A[i] ^ y[i]));
    end

    always_comb begin
        f_d     = f_q;
        cout_d  = cout_q;
        valid_d = en;
        if (en) begin
            f_d    = sum;
            cout_d = carry[WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_q     <= '0;
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            f_q     <= f_d;
            cout_q  <= cout_d;
            valid_q <= valid_d;
        end
    end

    assign F     = f_q;
    assign Cout  = cout_q;
    assign valid = valid_q;

`ifdef ARITH_STATUS_FLAGS_EN
    logic z_q, z_d;
    logic n_q, n_d;
    logic v_q, v_d;

    // Overflow: carry into the MSB disagrees with carry out of it.
    always_comb begin
        z_d = z_q;
        n_d = n_q;
        v_d = v_q;
        if (en) begin
            z_d = (sum == '0);
            n_d = sum[WIDTH-1];
            v_d = carry[WIDTH-1] ^ carry[WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_q <= 1'b0;
            n_q <= 1'b0;
            v_q <= 1'b0;
        end else begin
            z_q <= z_d;
            n_q <= n_d;
            v_q <= v_d;
        end
    end

    assign Z = z_q;
    assign N = n_q;
    assign V = v_q;
`endif

endmodule

// File: tb/tb_arithmetic_circuit.sv
// Scoreboard bench for arithmetic_circuit: directed vectors push expected results,
// a negedge monitor pops and compares whenever valid is high.
module tb_arithmetic_circuit;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] A, B;
    logic       s1, s0, Cin;
    logic [3:0] F;
    logic       Cout;
    logic       valid;
`ifdef ARITH_STATUS_FLAGS_EN
    logic       Z, N, V;
`endif

    arithmetic_circuit #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .A     (A),
        .B     (B),
        .s1    (s1),
        .s0    (s0),
        .Cin   (Cin),
        .F     (F),
        .Cout  (Cout),
        .valid (valid)
`ifdef ARITH_STATUS_FLAGS_EN
        ,
        .Z     (Z),
        .N     (N),
        .V     (V)
`endif
    );

    typedef struct {
        logic [3:0] f;
        logic       cout;
        logic       z;
        logic       n;
        logic       v;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   pops     = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Signed overflow of A + Y + Cin, evaluated on integers.
    function automatic logic ovf(input logic [3:0] a, input logic [3:0] b, input logic [2:0] sel);
        int sa, sy, s;
        logic [3:0] yv;
        case (sel[1:0])
            2'b00:   yv = b;
            2'b01:   yv = ~b;
            2'b10:   yv = 4'b0000;
            default: yv = 4'b1111;
        endcase
        sa = $signed(a);
        sy = $signed(yv);
        s  = sa + sy + int'(sel[2]);
        return (s > 7) || (s < -8);
    endfunction

    task automatic check1(input string name, input logic [3:0] act, input logic [3:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, req);
        end
    endtask

    // Drive one vector right after the next rising edge; it is captured on the edge after that.
    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [2:0] sel,
                         input logic e, input logic push,
                         input logic [3:0] ef, input logic ec);
        exp_t x;
        @(posedge clk);
        #1;
        A = a; B = b; Cin = sel[2]; s1 = sel[1]; s0 = sel[0]; en = e;
        if (push) begin
            x.f    = ef;
            x.cout = ec;
            x.z    = (ef == 4'b0000);
            x.n    = ef[3];
            x.v    = ovf(a, b, sel);
            exp_q.push_back(x);
        end
    endtask

    always @(negedge clk) begin
        if (valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid actual=1 required=0 F=%b", F);
            end else begin
                exp_t x;
                x = exp_q.pop_front();
                pops++;
                check1("sb_F", F, x.f);
                check1("sb_Cout", {3'b000, Cout}, {3'b000, x.cout});
`ifdef ARITH_STATUS_FLAGS_EN
                check1("sb_Z", {3'b000, Z}, {3'b000, x.z});
                check1("sb_N", {3'b000, N}, {3'b000, x.n});
                check1("sb_V", {3'b000, V}, {3'b000, x.v});
`endif
            end
        end
    end

    initial begin
        rst_n = 1'b0; en = 1'b0;
        A = 4'b0000; B = 4'b0000; Cin = 1'b0; s1 = 1'b0; s0 = 1'b0;
        #3;
        check1("rst_F", F, 4'b0000);
        check1("rst_Cout", {3'b000, Cout}, 4'b0000);
        check1("rst_valid", {3'b000, valid}, 4'b0000);
`ifdef ARITH_STATUS_FLAGS_EN
        check1("rst_flags", {1'b0, Z, N, V}, 4'b0000);
`endif
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Full function table, A=1001 B=1100, back to back
        drive(4'b1001, 4'b1100, 3'b000, 1'b1, 1'b1, 4'b0101, 1'b1);
        drive(4'b1001, 4'b1100, 3'b001, 1'b1, 1'b1, 4'b1100, 1'b0);
        drive(4'b1001, 4'b1100, 3'b010, 1'b1, 1'b1, 4'b1001, 1'b0);
        drive(4'b1001, 4'b1100, 3'b011, 1'b1, 1'b1, 4'b1000, 1'b1);
        drive(4'b1001, 4'b1100, 3'b100, 1'b1, 1'b1, 4'b0110, 1'b1);
        drive(4'b1001, 4'b1100, 3'b101, 1'b1, 1'b1, 4'b1101, 1'b0);
        drive(4'b1001, 4'b1100, 3'b110, 1'b1, 1'b1, 4'b1010, 1'b0);
        drive(4'b1001, 4'b1100, 3'b111, 1'b1, 1'b1, 4'b1001, 1'b1);
        // Wrap-around
        drive(4'b1111, 4'b0000, 3'b110, 1'b1, 1'b1, 4'b0000, 1'b1);
        drive(4'b0000, 4'b0000, 3'b011, 1'b1, 1'b1, 4'b1111, 1'b0);
        // Subtract without borrow, A >= B
        drive(4'b0111, 4'b0011, 3'b101, 1'b1, 1'b1, 4'b0100, 1'b1);
        // Load 0101, then hold with en=0 while inputs change
        drive(4'b1001, 4'b1100, 3'b000, 1'b1, 1'b1, 4'b0101, 1'b1);
        drive(4'b0110, 4'b0001, 3'b111, 1'b0, 1'b0, 4'b0000, 1'b0);
        drive(4'b1010, 4'b0101, 3'b001, 1'b0, 1'b0, 4'b0000, 1'b0);
        check1("hold_F", F, 4'b0101);
        check1("hold_Cout", {3'b000, Cout}, 4'b0001);
        check1("hold_valid", {3'b000, valid}, 4'b0000);
        drive(4'b0011, 4'b1111, 3'b100, 1'b0, 1'b0, 4'b0000, 1'b0);
        check1("hold2_F", F, 4'b0101);
        check1("hold2_valid", {3'b000, valid}, 4'b0000);

        // Pending capture killed by asynchronous reset between edges
        en = 1'b1; A = 4'b1111; B = 4'b1111; {Cin, s1, s0} = 3'b000;
        #2 rst_n = 1'b0;
        #1;
        check1("arst_F", F, 4'b0000);
        check1("arst_Cout", {3'b000, Cout}, 4'b0000);
        check1("arst_valid", {3'b000, valid}, 4'b0000);
        @(posedge clk);
        #1;
        check1("inrst_F", F, 4'b0000);
        check1("inrst_valid", {3'b000, valid}, 4'b0000);
        // Release with en held high: first capture on the first edge with rst_n=1
        A = 4'b1001; B = 4'b1100; {Cin, s1, s0} = 3'b000;
        begin
            exp_t x;
            x.f = 4'b0101; x.cout = 1'b1; x.z = 1'b0; x.n = 1'b0;
            x.v = ovf(4'b1001, 4'b1100, 3'b000);
            exp_q.push_back(x);
        end
        #2 rst_n = 1'b1;
        drive(4'b0000, 4'b0000, 3'b010, 1'b0, 1'b0, 4'b0000, 1'b0);

        begin
            int n;
            n = 0;
            while (exp_q.size() != 0 && n < 20) begin
                @(posedge clk);
                n++;
            end
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d_pending required=0_pending", exp_q.size());
        end
        checks++;
        if (pops != 13) begin
            failures++;
            $display("FAIL valid_count actual=%0d required=13", pops);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
